// File: rtl/md_pkg.sv
// Shared encodings, state enum and sizing for the multiply/divide sequencer.
package md_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_ITER  = 32;
   localparam int unsigned MD_CNT_W = 5;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } md_state_e;

   // Magnitude of a two's-complement value when the op is signed; raw value otherwise.
   function automatic logic [MD_WIDTH-1:0] md_mag(input logic [MD_WIDTH-1:0] v, input logic sgn);
      return (sgn && v[MD_WIDTH-1]) ? MD_WIDTH'(-v) : v;
   endfunction

endpackage

// File: rtl/md_seq_ctrl_if.sv
// Execute-stage side bundle of the multiply/divide sequencer.
interface md_seq_ctrl_if;
   import md_pkg::*;

   logic                md_start;
   logic [1:0]          md_op;
   logic [MD_WIDTH-1:0] md_src1;
   logic [MD_WIDTH-1:0] md_src2;
   logic                cancel;
   logic                md_busy;
   logic                md_done;
   logic [MD_WIDTH-1:0] md_hi;
   logic [MD_WIDTH-1:0] md_lo;

   modport master (
      output md_start, md_op, md_src1, md_src2, cancel,
      input  md_busy, md_done, md_hi, md_lo
   );

   modport slave (
      input  md_start, md_op, md_src1, md_src2, cancel,
      output md_busy, md_done, md_hi, md_lo
   );

endinterface

// File: rtl/md_datapath.sv
// Shared shift register, operand magnitudes, add/sub and result sign fix-up.
module md_datapath
   import md_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                ld,
   input  logic                ld_mul,
   input  logic                ld_signed,
   input  logic [MD_WIDTH-1:0] src1,
   input  logic [MD_WIDTH-1:0] src2,
   input  logic                step,
   input  logic                is_mul,
   input  logic                neg_main,
   input  logic                neg_rem,
   input  logic                div0,
   output logic [MD_WIDTH-1:0] res_hi,
   output logic [MD_WIDTH-1:0] res_lo
);

   localparam int unsigned W = MD_WIDTH;

   logic [W-1:0]   mag1_q, mag2_q;
   logic [2*W-1:0] acc_q, acc_d, prod_neg;
   logic [W:0]     add_a, add_b, add_s;
   logic [W-1:0]   mag1_d, mag2_d;

   // One adder: add-multiplicand for MUL, trial-subtract divisor for DIV.
   always_comb begin
      add_a = is_mul ? {1'b0, acc_q[2*W-1:W]} : acc_q[2*W-1:W-1];
      add_b = '0;
      if (!is_mul || acc_q[0]) begin
         add_b = is_mul ? {1'b0, mag1_q} : {1'b0, mag2_q};
      end
      add_s = is_mul ? (add_a + add_b) : (add_a - add_b);
      if (is_mul) begin
         acc_d = {add_s, acc_q[W-1:1]};
      end else if (add_s[W]) begin
         acc_d = {acc_q[2*W-2:0], 1'b0};
      end else begin
         acc_d = {add_s[W-1:0], acc_q[W-2:0], 1'b1};
      end
   end

   // Operand capture at start; accumulator starts with multiplier or dividend.
   always_comb begin
      mag1_d = md_mag(src1, ld_signed);
      mag2_d = md_mag(src2, ld_signed);
   end

   // Operand and accumulator registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mag1_q <= '0;
         mag2_q <= '0;
         acc_q  <= '0;
      end else if (ld) begin
         mag1_q <= mag1_d;
         mag2_q <= mag2_d;
         acc_q  <= {{W{1'b0}}, (ld_mul ? mag2_d : mag1_d)};
      end else if (step) begin
         acc_q  <= acc_d;
      end
   end

   // Sign correction of the finished magnitude result; divide-by-zero bypasses it.
   always_comb begin
      prod_neg = (2*W)'(-acc_q);
      if (div0) begin
         res_hi = mag1_q;
         res_lo = '1;
      end else if (is_mul) begin
         res_hi = neg_main ? prod_neg[2*W-1:W] : acc_q[2*W-1:W];
         res_lo = neg_main ? prod_neg[W-1:0]   : acc_q[W-1:0];
      end else begin
         res_hi = neg_rem  ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
         res_lo = neg_main ? W'(-acc_q[W-1:0])   : acc_q[W-1:0];
      end
   end

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: FSM, iteration counter, sign latches, HI/LO.
module md_seq_ctrl
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   md_seq_ctrl_if.slave md
);

   md_state_e             state_q, state_d;
   logic [MD_CNT_W-1:0]   cnt_q;
   logic                  is_mul_q, sign1_q, sign2_q, div0_q;
   logic [MD_WIDTH-1:0]   hi_q, lo_q;
   logic [MD_WIDTH-1:0]   res_hi, res_lo;
   logic                  busy_c, done_c, step_c, load_c;
   logic                  accept_c, div0_c, signed_c, last_c;

   assign accept_c = md.md_start & ~busy_c & ~md.cancel;
   assign div0_c   = md.md_op[1] & (md.md_src2 == '0);
   assign signed_c = ~md.md_op[0];
   assign last_c   = (cnt_q == MD_CNT_W'(MD_ITER - 1));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; cancel overrides everything.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept_c) begin
               if (!md.md_op[1]) state_d = ST_MUL;
               else if (div0_c)  state_d = ST_FIX;
               else              state_d = ST_DIV;
            end
         end
         ST_MUL:  if (last_c) state_d = ST_FIX;
         ST_DIV:  if (last_c) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      if (md.cancel) state_d = ST_IDLE;
   end

   // State-decoded outputs and datapath controls.
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      step_c = 1'b0;
      load_c = 1'b0;
      unique case (state_q)
         ST_MUL, ST_DIV: begin
            busy_c = 1'b1;
            step_c = 1'b1;
         end
         ST_FIX: begin
            busy_c = 1'b1;
            load_c = ~md.cancel;
         end
         ST_DONE: done_c = 1'b1;
         default: ;
      endcase
   end

   // Iteration counter and per-operation mode/sign latches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         div0_q   <= 1'b0;
      end else if (accept_c) begin
         cnt_q    <= '0;
         is_mul_q <= ~md.md_op[1];
         sign1_q  <= signed_c & md.md_src1[MD_WIDTH-1];
         sign2_q  <= signed_c & md.md_src2[MD_WIDTH-1];
         div0_q   <= div0_c;
      end else if (step_c) begin
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   // HI/LO result registers, written only on an uncancelled FIX.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (load_c) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end
   end

   md_datapath u_datapath (
      .clk       (clk),
      .resetn    (resetn),
      .ld        (accept_c),
      .ld_mul    (~md.md_op[1]),
      .ld_signed (signed_c & ~div0_c),
      .src1      (md.md_src1),
      .src2      (md.md_src2),
      .step      (step_c),
      .is_mul    (is_mul_q),
      .neg_main  (sign1_q ^ sign2_q),
      .neg_rem   (sign1_q),
      .div0      (div0_q),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   assign md.md_busy = busy_c;
   assign md.md_done = done_c;
   assign md.md_hi   = hi_q;
   assign md.md_lo   = lo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed self-checking bench for md_seq_ctrl.
module tb_md_seq_ctrl;
   import md_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   errors  = 0;

   md_seq_ctrl_if bus ();

   md_seq_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .md     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in the current cycle (cycle 0) and follow it to md_done.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int cyc;
      int bcnt;
      bus.md_start = 1'b1;
      bus.md_op    = op;
      bus.md_src1  = a;
      bus.md_src2  = b;
      tick();
      bus.md_start = 1'b0;
      cyc  = 1;
      bcnt = 0;
      while (bus.md_done !== 1'b1 && cyc < 80) begin
         if (bus.md_busy === 1'b1) bcnt++;
         tick();
         cyc++;
      end
      check({tag, ".done_cycle"}, 32'(cyc), 32'(lat));
      check({tag, ".busy_cycles"}, 32'(bcnt), 32'(lat - 1));
      check({tag, ".busy_at_done"}, {31'b0, bus.md_busy}, 32'h0);
      check({tag, ".hi"}, bus.md_hi, ehi);
      check({tag, ".lo"}, bus.md_lo, elo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_done;
      resetn       = 1'b0;
      bus.md_start = 1'b0;
      bus.md_op    = MD_MULT;
      bus.md_src1  = '0;
      bus.md_src2  = '0;
      bus.cancel   = 1'b0;
      #12;
      check("reset.busy", {31'b0, bus.md_busy}, 32'h0);
      check("reset.done", {31'b0, bus.md_done}, 32'h0);
      check("reset.hi", bus.md_hi, 32'h0);
      check("reset.lo", bus.md_lo, 32'h0);
      tick();
      resetn = 1'b1;
      tick();

      run_op("mult_max_x2", MD_MULT,  32'h7FFF_FFFF, 32'h0000_0002, 34, 32'h0000_0000, 32'hFFFF_FFFE);
      run_op("mult_m3_x5",  MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_ones",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7_2",    MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100_7",  MD_DIVU,  32'd100,       32'd7,         34, 32'h0000_0002, 32'h0000_000E);
      run_op("div_min_m1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_5_0",    MD_DIVU,  32'd5,         32'd0,         2,  32'h0000_0005, 32'hFFFF_FFFF);
      run_op("div_m5_0",    MD_DIV,   32'hFFFF_FFFB, 32'd0,         2,  32'hFFFF_FFFB, 32'hFFFF_FFFF);

      // Cancel a MULT in cycle 10; HI/LO must keep the previous result.
      bus.md_start = 1'b1;
      bus.md_op    = MD_MULT;
      bus.md_src1  = 32'd3;
      bus.md_src2  = 32'd4;
      tick();
      bus.md_start = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c < 10; c++) begin
         saw_done |= bus.md_done;
         tick();
      end
      saw_done |= bus.md_done;
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("cancel.busy_c11", {31'b0, bus.md_busy}, 32'h0);
      check("cancel.no_done", {31'b0, saw_done | bus.md_done}, 32'h0);
      check("cancel.hi_kept", bus.md_hi, 32'hFFFF_FFFB);
      check("cancel.lo_kept", bus.md_lo, 32'hFFFF_FFFF);
      run_op("divu_after_cancel", MD_DIVU, 32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E);

      // Start together with cancel is ignored.
      bus.md_start = 1'b1;
      bus.md_op    = MD_MULTU;
      bus.md_src1  = 32'd9;
      bus.md_src2  = 32'd9;
      bus.cancel   = 1'b1;
      tick();
      bus.md_start = 1'b0;
      bus.cancel   = 1'b0;
      check("cancel_start.busy", {31'b0, bus.md_busy}, 32'h0);
      check("cancel_start.done", {31'b0, bus.md_done}, 32'h0);
      tick();
      check("cancel_start.busy2", {31'b0, bus.md_busy}, 32'h0);

      // Asynchronous reset in the middle of a multiply.
      bus.md_start = 1'b1;
      bus.md_op    = MD_MULT;
      bus.md_src1  = 32'h0000_1234;
      bus.md_src2  = 32'h0000_0010;
      tick();
      bus.md_start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      #2;
      resetn = 1'b0;
      #1;
      check("areset.busy", {31'b0, bus.md_busy}, 32'h0);
      check("areset.done", {31'b0, bus.md_done}, 32'h0);
      check("areset.hi", bus.md_hi, 32'h0);
      check("areset.lo", bus.md_lo, 32'h0);
      tick();
      resetn = 1'b1;
      tick();
      check("areset.idle_busy", {31'b0, bus.md_busy}, 32'h0);

      // Back-to-back: each op is started in the DONE cycle of the previous one.
      run_op("b2b_multu_6x7", MD_MULTU, 32'd6,         32'd7, 34, 32'h0000_0000, 32'h0000_002A);
      run_op("b2b_div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("b2b_divu_9_0",  MD_DIVU,  32'd9,         32'd0, 2,  32'h0000_0009, 32'hFFFF_FFFF);
      tick();
      check("final.done_pulse", {31'b0, bus.md_done}, 32'h0);
      check("final.hi_hold", bus.md_hi, 32'h0000_0009);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
